// File: rtl/param_work_fsm_pkg.sv
// Shared state encoding for the programmable-length work sequencer.
// The numeric codes are fixed so external scoreboards can mirror them.
package param_work_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WORK  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == START) || (st == WORK);
  endfunction

endpackage

// File: rtl/param_work_fsm.sv
// IDLE -> START -> WORK(len cycles) -> DONE sequencer with abort path,
// remaining-cycle count and selectable pulse/held done indication.
module param_work_fsm
  import param_work_fsm_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, done_q, aborted_q;

  // Next-state and down-counter; illegal codes fall back to IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          count_d = len;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (abort) begin
          state_d = ABORT;
        end else if (count_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = WORK;
        end
      end
      WORK: begin
        if (abort) begin
          state_d = ABORT;
        end else if (count_q <= CNT_W'(1)) begin
          // Last work cycle; also guards against underflow from a zero count.
          state_d = DONE;
          count_d = {CNT_W{1'b0}};
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!DONE_HOLD || ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      ABORT: begin
        state_d = IDLE;
        count_d = {CNT_W{1'b0}};
      end
      default: begin
        state_d = IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= is_busy(state_d);
      done_q    <= (state_d == DONE);
      aborted_q <= (state_d == ABORT);
    end
  end

  assign state   = state_q;
  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_param_work_fsm.sv
// Self-checking bench: three instances (pulse done, held done, 4-bit count)
// compared each cycle against a time-indexed operation model.
module tb_param_work_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st  [3];
  logic       ab  [3];
  logic       ak  [3];
  logic [7:0] ln  [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       abt_o  [3];
  logic [2:0] state_o[3];
  logic [7:0] cnt0_s, cnt1_s;
  logic [3:0] cnt2_s;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 running (t=0 START, t=1..len WORK), 2 done, 3 aborted.
  int m_mode[3];
  int m_t   [3];
  int m_len [3];
  int m_frz [3];
  int hold  [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  param_work_fsm #(.CNT_W(8), .DONE_HOLD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .len(ln[0]), .abort(ab[0]), .ack(ak[0]),
    .busy(busy_o[0]), .done(done_o[0]), .aborted(abt_o[0]), .count(cnt0_s), .state(state_o[0]));

  param_work_fsm #(.CNT_W(8), .DONE_HOLD(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .len(ln[1]), .abort(ab[1]), .ack(ak[1]),
    .busy(busy_o[1]), .done(done_o[1]), .aborted(abt_o[1]), .count(cnt1_s), .state(state_o[1]));

  param_work_fsm #(.CNT_W(4), .DONE_HOLD(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .len(ln[2][3:0]), .abort(ab[2]), .ack(ak[2]),
    .busy(busy_o[2]), .done(done_o[2]), .aborted(abt_o[2]), .count(cnt2_s), .state(state_o[2]));

  function automatic int run_count(input int i);
    return (m_t[i] == 0) ? m_len[i] : m_len[i] - (m_t[i] - 1);
  endfunction

  function automatic int exp_state(input int i);
    case (m_mode[i])
      1:       return (m_t[i] == 0) ? 1 : 2;
      2:       return 3;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_count(input int i);
    case (m_mode[i])
      1:       return run_count(i);
      3:       return m_frz[i];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_t[i] = 0; m_len[i] = 0; m_frz[i] = 0;
    end
  endtask

  // Advance the model with the inputs present just before the active edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      case (m_mode[i])
        0: if (st[i]) begin
             m_mode[i] = 1;
             m_t[i]    = 0;
             m_len[i]  = (i == 2) ? int'(ln[i][3:0]) : int'(ln[i]);
           end
        1: if (ab[i]) begin
             m_frz[i]  = run_count(i);
             m_mode[i] = 3;
           end else if (m_t[i] == m_len[i]) begin
             m_mode[i] = 2;
           end else begin
             m_t[i] = m_t[i] + 1;
           end
        2: if (hold[i] == 0 || ak[i]) m_mode[i] = 0;
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] c;
    int es;
    for (int i = 0; i < 3; i++) begin
      c  = (i == 0) ? {24'd0, cnt0_s} : (i == 1) ? {24'd0, cnt1_s} : {28'd0, cnt2_s};
      es = exp_state(i);
      chk("state",   i, {29'd0, state_o[i]}, es);
      chk("count",   i, c, exp_count(i));
      chk("busy",    i, {31'd0, busy_o[i]}, (es == 1 || es == 2) ? 1 : 0);
      chk("done",    i, {31'd0, done_o[i]}, (es == 3) ? 1 : 0);
      chk("aborted", i, {31'd0, abt_o[i]}, (es == 4) ? 1 : 0);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; ak[i] = 1'b0; ln[i] = 8'd0;
    end
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Basic run, len=4.
    ln[0] = 8'd4; st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(7);

    // len=0 skips WORK.
    ln[0] = 8'd0; st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(3);

    // Abort on the third WORK cycle of a len=10 run.
    ln[0] = 8'd10; st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(3);
    ab[0] = 1'b1;
    tick(1);
    ab[0] = 1'b0;
    tick(3);

    // start+abort together in IDLE: start wins; then abort straight out of START.
    ln[0] = 8'd3; st[0] = 1'b1; ab[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(1);
    ab[0] = 1'b0;
    tick(2);

    // Held done: ack low for 5 cycles with start pulses, then ack.
    ln[1] = 8'd2; st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      st[1] = k[0];
      ab[1] = ~k[0];
      tick(1);
    end
    st[1] = 1'b0; ab[1] = 1'b0; ak[1] = 1'b1;
    tick(1);
    ak[1] = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of WORK.
    ln[0] = 8'd8; st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    ln[0] = 8'd1; st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(4);

    // Maximum length on the 4-bit instance with start held high.
    ln[2] = 8'd15; st[2] = 1'b1;
    tick(40);
    st[2] = 1'b0;
    tick(20);

    // Randomized traffic on all instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        st[i] = ($urandom_range(0, 3) == 0);
        ab[i] = ($urandom_range(0, 11) == 0);
        ak[i] = ($urandom_range(0, 4) == 0);
        ln[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      end
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
